// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: PC sequencing control FSM for a multicycle MIPS-style core.
// Drives fetch, decode redirect, branch, execute hand-off and exception vectoring.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   opcode     in   IR[31:26], valid from DECODE onward
//   funct      in   IR[5:0]
//   zero       in   ALU zero flag
//   ovf        in   ALU overflow flag
//   illegal    in   decoder flags unsupported opcode/funct
//   exec_done  in   main control finished execute/writeback
//   pc_write   out  PC load enable
//   pc_source  out  PC mux select (0 PC+4, 1 branch, 2 jump, 3 EPC, 4 vector, 5 rs)
//   iord       out  memory address select (0 PC, 1 vector address)
//   mem_read   out  memory read strobe
//   ir_write   out  IR load enable
//   epc_write  out  EPC load enable
//   exc_cause  out  registered cause (0 none, 1 illegal, 2 overflow)
//   state_o    out  current state encoding (debug)
module pc_seq_ctrl #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       ovf,
    input  logic       illegal,
    input  logic       exec_done,
    output logic       pc_write,
    output logic [2:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       ir_write,
    output logic       epc_write,
    output logic [1:0] exc_cause,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_FWAIT  = 4'd2,
        S_DECODE = 4'd3,
        S_BRANCH = 4'd4,
        S_EXEC   = 4'd5,
        S_EXC    = 4'd6,
        S_XWAIT  = 4'd7,
        S_XLOAD  = 4'd8
    } state_t;

    localparam logic [2:0] PC_SEQ = 3'd0;
    localparam logic [2:0] PC_BR  = 3'd1;
    localparam logic [2:0] PC_J   = 3'd2;
    localparam logic [2:0] PC_EPC = 3'd3;
    localparam logic [2:0] PC_VEC = 3'd4;
    localparam logic [2:0] PC_RS  = 3'd5;

    localparam logic [1:0] CAUSE_ILL = 2'd1;
    localparam logic [1:0] CAUSE_OVF = 2'd2;

    localparam logic [5:0] OP_SPEC = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_RTE  = 6'h10;
    localparam logic [5:0] FN_JR   = 6'h08;

    // Counter preload: the waiting state runs MEM_LAT cycles, counting down to 0.
    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q,   cnt_d;
    logic [1:0] cause_q, cause_d;
    logic [5:0] brop_q,  brop_d;

    logic is_jump;
    logic is_jr;
    logic is_rte;
    logic is_branch;
    logic br_take;

    assign is_jump   = (opcode == OP_J) || (opcode == OP_JAL);
    assign is_jr     = (opcode == OP_SPEC) && (funct == FN_JR);
    assign is_rte    = (opcode == OP_RTE);
    assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);

    // Branch resolution uses the opcode captured in DECODE, since the live
    // opcode may already be changing by the time BRANCH evaluates.
    assign br_take = ((brop_q == OP_BEQ) &&  zero) ||
                     ((brop_q == OP_BNE) && !zero);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        brop_d    = brop_q;
        pc_write  = 1'b0;
        pc_source = PC_SEQ;
        iord      = 1'b0;
        mem_read  = 1'b0;
        ir_write  = 1'b0;
        epc_write = 1'b0;

        case (state_q)
            S_RST: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                mem_read = 1'b1;
                cnt_d    = LAT_M1;
                state_d  = S_FWAIT;
            end

            S_FWAIT: begin
                mem_read = 1'b1;
                if (cnt_q == 3'd0) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    pc_source = PC_SEQ;
                    state_d   = S_DECODE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            S_DECODE: begin
                brop_d = opcode;
                if (illegal) begin
                    cause_d = CAUSE_ILL;
                    state_d = S_EXC;
                end else if (is_jump) begin
                    pc_write  = 1'b1;
                    pc_source = PC_J;
                    state_d   = S_FETCH;
                end else if (is_jr) begin
                    pc_write  = 1'b1;
                    pc_source = PC_RS;
                    state_d   = S_FETCH;
                end else if (is_rte) begin
                    pc_write  = 1'b1;
                    pc_source = PC_EPC;
                    state_d   = S_FETCH;
                end else if (is_branch) begin
                    state_d = S_BRANCH;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_BRANCH: begin
                if (br_take) begin
                    pc_write  = 1'b1;
                    pc_source = PC_BR;
                end
                state_d = S_FETCH;
            end

            // Overflow wins over completion when both arrive together.
            S_EXEC: begin
                if (ovf) begin
                    cause_d = CAUSE_OVF;
                    state_d = S_EXC;
                end else if (exec_done) begin
                    state_d = S_FETCH;
                end
            end

            S_EXC: begin
                epc_write = 1'b1;
                cnt_d     = LAT_M1;
                state_d   = S_XWAIT;
            end

            S_XWAIT: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (cnt_q == 3'd0) begin
                    state_d = S_XLOAD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            S_XLOAD: begin
                pc_write  = 1'b1;
                pc_source = PC_VEC;
                state_d   = S_FETCH;
            end

            default: begin
                state_d = S_RST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_RST;
            cnt_q   <= 3'd0;
            cause_q <= 2'd0;
            brop_q  <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            brop_q  <= brop_d;
        end
    end

    assign exc_cause = cause_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: directed-vector bench for pc_seq_ctrl at MEM_LAT=2.
// Outputs are sampled 1ns after the falling edge; inputs change on it.
module tb_pc_seq_ctrl;

    localparam logic [3:0] RST = 4'd0, FET = 4'd1, FWT = 4'd2, DEC = 4'd3;
    localparam logic [3:0] BRA = 4'd4, EXE = 4'd5, EXC = 4'd6, XWT = 4'd7;
    localparam logic [3:0] XLD = 4'd8;

    // {pc_write, pc_source[2:0], iord, mem_read, ir_write, epc_write}
    localparam logic [7:0] O_NONE = 8'b0000_0000;
    localparam logic [7:0] O_FET  = 8'b0000_0100;
    localparam logic [7:0] O_FIRE = 8'b1000_0110;
    localparam logic [7:0] O_BR   = 8'b1001_0000;
    localparam logic [7:0] O_J    = 8'b1010_0000;
    localparam logic [7:0] O_RTE  = 8'b1011_0000;
    localparam logic [7:0] O_XL   = 8'b1100_0000;
    localparam logic [7:0] O_JR   = 8'b1101_0000;
    localparam logic [7:0] O_XW   = 8'b0000_1100;
    localparam logic [7:0] O_EPC  = 8'b0000_0001;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero, ovf, illegal, exec_done;
    logic       pc_write, iord, mem_read, ir_write, epc_write;
    logic [2:0] pc_source;
    logic [1:0] exc_cause;
    logic [3:0] state_o;
    logic [7:0] outs;

    int vectors = 0;
    int errs    = 0;
    logic [1:0] exp_cause = 2'd0;

    always #5 clk = ~clk;

    assign outs = {pc_write, pc_source, iord, mem_read, ir_write, epc_write};

    pc_seq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .ovf       (ovf),
        .illegal   (illegal),
        .exec_done (exec_done),
        .pc_write  (pc_write),
        .pc_source (pc_source),
        .iord      (iord),
        .mem_read  (mem_read),
        .ir_write  (ir_write),
        .epc_write (epc_write),
        .exc_cause (exc_cause),
        .state_o   (state_o)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Check the current cycle, then advance to the next falling edge.
    task automatic step(input string tag, input logic [3:0] st,
                        input logic [7:0] o);
        #1;
        check({tag, "/st"}, 32'(state_o), 32'(st));
        check({tag, "/out"}, 32'(outs), 32'(o));
        if (st != EXC)
            check({tag, "/cause"}, 32'(exc_cause), 32'(exp_cause));
        @(negedge clk);
    endtask

    task automatic fetch(input string tag);
        step({tag, ".f0"}, FET, O_FET);
        step({tag, ".f1"}, FWT, O_FET);
        step({tag, ".f2"}, FWT, O_FIRE);
    endtask

    initial begin
        reset = 1'b0; opcode = 6'h00; funct = 6'h00;
        zero = 1'b0; ovf = 1'b0; illegal = 1'b0; exec_done = 1'b0;
        @(negedge clk);
        step("rst0", RST, O_NONE);
        step("rst1", RST, O_NONE);

        // Reset release, ALU op, exec_done on third EXEC cycle.
        reset = 1'b1;
        step("rel", RST, O_NONE);
        opcode = 6'h00; funct = 6'h20;
        fetch("add");
        step("add.dec", DEC, O_NONE);
        step("add.e0", EXE, O_NONE);
        step("add.e1", EXE, O_NONE);
        exec_done = 1'b1;
        step("add.e2", EXE, O_NONE);
        exec_done = 1'b0;

        // BEQ taken; live opcode flipped during BRANCH must not matter.
        opcode = 6'h04; funct = 6'h00; zero = 1'b1;
        fetch("beq");
        step("beq.dec", DEC, O_NONE);
        opcode = 6'h05;
        step("beq.br", BRA, O_BR);

        // BNE with zero=1: not taken, live opcode flipped to BEQ.
        opcode = 6'h05;
        fetch("bne");
        step("bne.dec", DEC, O_NONE);
        opcode = 6'h04;
        step("bne.br", BRA, O_NONE);

        // BNE with zero=0: taken.
        opcode = 6'h05; zero = 1'b0;
        fetch("bnt");
        step("bnt.dec", DEC, O_NONE);
        step("bnt.br", BRA, O_BR);

        // Illegal beats J in DECODE.
        opcode = 6'h02; illegal = 1'b1;
        fetch("ill");
        step("ill.dec", DEC, O_NONE);
        illegal = 1'b0;
        step("ill.exc", EXC, O_EPC);
        exp_cause = 2'd1;
        step("ill.xw0", XWT, O_XW);
        step("ill.xw1", XWT, O_XW);
        step("ill.xld", XLD, O_XL);

        // Overflow and exec_done together: exception wins.
        opcode = 6'h00; funct = 6'h20;
        fetch("ovf");
        step("ovf.dec", DEC, O_NONE);
        ovf = 1'b1; exec_done = 1'b1;
        step("ovf.ex", EXE, O_NONE);
        ovf = 1'b0; exec_done = 1'b0;
        step("ovf.exc", EXC, O_EPC);
        exp_cause = 2'd2;
        step("ovf.xw0", XWT, O_XW);
        step("ovf.xw1", XWT, O_XW);
        step("ovf.xld", XLD, O_XL);

        // Reset asserted in the middle of exception vector read.
        opcode = 6'h23;
        fetch("rx");
        step("rx.dec", DEC, O_NONE);
        step("rx.e0", EXE, O_NONE);
        ovf = 1'b1;
        step("rx.e1", EXE, O_NONE);
        ovf = 1'b0;
        step("rx.exc", EXC, O_EPC);
        reset = 1'b0;
        step("rx.xw0", XWT, O_XW);
        exp_cause = 2'd0;
        step("rx.rst", RST, O_NONE);
        reset = 1'b1;
        step("rx.rel", RST, O_NONE);

        // JR, RTE, J, JAL redirects: single-cycle pc_write each.
        opcode = 6'h00; funct = 6'h08;
        fetch("jr");
        step("jr.dec", DEC, O_JR);
        opcode = 6'h10; funct = 6'h00;
        fetch("rte");
        step("rte.dec", DEC, O_RTE);
        opcode = 6'h02;
        fetch("j");
        step("j.dec", DEC, O_J);
        opcode = 6'h03;
        fetch("jal");
        step("jal.dec", DEC, O_J);
        step("end", FET, O_FET);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
